// File: rtl/rf_read_stage.sv
// Operand-read stage: scoreboards in-flight writebacks, stalls on RAW/WAW, registers operands for execute.
// Optional RF_FWD_EN: a writeback landing in the accept cycle is forwarded instead of stalling.
module rf_read_stage #(
  parameter int SCALAR_W = 21,
  parameter int VECTOR_W = 192,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [ADDR_W-1:0]   src2,
  input  logic                srcType,
  input  logic [ADDR_W-1:0]   dest,
  input  logic                destType,
  input  logic [1:0]          wb,
  output logic [ADDR_W-1:0]   rf_a1,
  output logic [ADDR_W-1:0]   rf_a2,
  input  logic [SCALAR_W-1:0] rf_r1e,
  input  logic [SCALAR_W-1:0] rf_r2e,
  input  logic [VECTOR_W-1:0] rf_r1v,
  input  logic [VECTOR_W-1:0] rf_r2v,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_dest,
  input  logic                wb_destType,
  input  logic [SCALAR_W-1:0] wb_dataE,
  input  logic [VECTOR_W-1:0] wb_dataV,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SCALAR_W-1:0] op1e,
  output logic [SCALAR_W-1:0] op2e,
  output logic [VECTOR_W-1:0] op1v,
  output logic [VECTOR_W-1:0] op2v,
  output logic [ADDR_W-1:0]   out_dest,
  output logic                out_destType,
  output logic [1:0]          out_wb,
  output logic [1:0]          fsm_state
);

  localparam int NREG = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } state_t;

  // Handshake: a beat moves on either side only in a cycle where valid && ready;
  // ready never looks at valid, and a held bundle stays frozen until out_ready.

  logic            held_q, held_d;
  logic [NREG-1:0] pend_e, pend_v;
  logic [NREG-1:0] src_pend, dst_pend;
  logic            fwd1, fwd2, fwd_d;
  logic            hazard, accept;
  logic [NREG-1:0] set_mask, clr_mask;
  logic [SCALAR_W-1:0] d1e, d2e;
  logic [VECTOR_W-1:0] d1v, d2v;
  state_t          state;

  assign rf_a1     = src1;
  assign rf_a2     = src2;
  assign out_valid = held_q;
  assign fsm_state = state;

  assign src_pend = srcType  ? pend_v : pend_e;
  assign dst_pend = destType ? pend_v : pend_e;

`ifdef RF_FWD_EN
  assign fwd1  = wb_valid && (wb_destType == srcType)  && (wb_dest == src1);
  assign fwd2  = wb_valid && (wb_destType == srcType)  && (wb_dest == src2);
  assign fwd_d = wb_valid && (wb_destType == destType) && (wb_dest == dest);
`else
  // Clears land at the edge; the synchronous-write bank is readable one cycle later.
  assign fwd1  = 1'b0;
  assign fwd2  = 1'b0;
  assign fwd_d = 1'b0;
`endif

  assign d1e = fwd1 ? wb_dataE : rf_r1e;
  assign d2e = fwd2 ? wb_dataE : rf_r2e;
  assign d1v = fwd1 ? wb_dataV : rf_r1v;
  assign d2v = fwd2 ? wb_dataV : rf_r2v;

  always_comb begin
    hazard = 1'b0;
    if (src_pend[src1] && !fwd1) hazard = 1'b1;
    if (src_pend[src2] && !fwd2) hazard = 1'b1;
    if (wb[0] && dst_pend[dest] && !fwd_d) hazard = 1'b1;
  end

  assign in_ready = (!held_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // State register: FULL is the only stored state; STALL is derived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) held_q <= 1'b0;
    else        held_q <= held_d;
  end

  always_comb begin
    held_d = held_q;
    if (accept)         held_d = 1'b1;
    else if (out_ready) held_d = 1'b0;
  end

  always_comb begin
    state = ST_EMPTY;
    if (held_q)                  state = ST_FULL;
    else if (in_valid && hazard) state = ST_STALL;
  end

  assign set_mask = (accept && wb[0]) ? (NREG'(1) << dest) : '0;
  assign clr_mask = wb_valid ? (NREG'(1) << wb_dest) : '0;

  // Set is applied after clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_e <= '0;
      pend_v <= '0;
    end else begin
      pend_e <= (pend_e & ~(wb_destType ? '0 : clr_mask)) | (destType ? '0 : set_mask);
      pend_v <= (pend_v & ~(wb_destType ? clr_mask : '0)) | (destType ? set_mask : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1e         <= '0;
      op2e         <= '0;
      op1v         <= '0;
      op2v         <= '0;
      out_dest     <= '0;
      out_destType <= 1'b0;
      out_wb       <= '0;
    end else if (accept) begin
      op1e         <= srcType ? '0 : d1e;
      op2e         <= srcType ? '0 : d2e;
      op1v         <= srcType ? d1v : '0;
      op2v         <= srcType ? d2v : '0;
      out_dest     <= dest;
      out_destType <= destType;
      out_wb       <= wb;
    end
  end

endmodule

// File: doc/rf_read_stage.md
Name: rf_read_stage

Overview:
- Operand-read stage of the vector processor. Sits between decode and execute, facing the same File_Register bank that writeback updates.
- Accepts one decoded instruction per cycle through a valid/ready handshake and drives the register-file read addresses.
- Tracks in-flight writebacks in a scalar/vector scoreboard and stalls on RAW/WAW hazards.
- Registers the operands for execute with one cycle of latency.

Parameters:
- SCALAR_W, 21, scalar element register width
- VECTOR_W, 192, vector register width
- ADDR_W, 4, register address width; 2**ADDR_W registers per type

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- src1  in  ADDR_W  first source register
- src2  in  ADDR_W  second source register
- srcType  in  1  source type: 0 = scalar, 1 = vector (applies to both sources)
- dest  in  ADDR_W  destination register
- destType  in  1  destination type: 0 = scalar, 1 = vector
- wb  in  2  writeback control, passed through; wb[0] = instruction writes a register
- rf_a1  out  ADDR_W  register-file read address 1; combinational = src1
- rf_a2  out  ADDR_W  register-file read address 2; combinational = src2
- rf_r1e  in  SCALAR_W  register-file scalar read data, port 1 (combinational)
- rf_r2e  in  SCALAR_W  register-file scalar read data, port 2 (combinational)
- rf_r1v  in  VECTOR_W  register-file vector read data, port 1 (combinational)
- rf_r2v  in  VECTOR_W  register-file vector read data, port 2 (combinational)
- wb_valid  in  1  writeback stage commits a write this cycle
- wb_dest  in  ADDR_W  writeback destination register
- wb_destType  in  1  writeback destination type
- wb_dataE  in  SCALAR_W  scalar data being written back
- wb_dataV  in  VECTOR_W  vector data being written back
- out_valid  out  1  operand bundle valid toward execute
- out_ready  in  1  execute accepts the bundle
- op1e  out  SCALAR_W  scalar operand 1
- op2e  out  SCALAR_W  scalar operand 2
- op1v  out  VECTOR_W  vector operand 1
- op2v  out  VECTOR_W  vector operand 2
- out_dest  out  ADDR_W  destination, forwarded to the next stage
- out_destType  out  1  destination type, forwarded
- out_wb  out  2  writeback control, forwarded

Behaviour:
- Reset, asynchronous on rst_n low: out_valid=0; op*/out_* = 0; both scoreboards (pendE[15:0], pendV[15:0]) = 0; state=EMPTY.
- States:
  - EMPTY: no bundle held.
  - FULL: bundle held, out_valid=1.
  - STALL: in_valid=1 with a hazard, no bundle held. Derived from registers plus inputs, no extra flop required.
- Hazard: srcN's pending bit (pendE if srcType=0, else pendV) is set and not cleared by this cycle's wb. Also a hazard: wb[0]=1 and the dest pending bit of destType is set (WAW), unless cleared this cycle.
- in_ready = (!out_valid || out_ready) && !hazard. Combinational; in_ready does not depend on in_valid.
- Accept: operands captured next edge, so latency is 1 cycle and out_valid rises the cycle after accept.
  - Selected type's operands = register-file data, or forwarded data (see Optional Feature).
  - Unselected type's operands = 0.
- Hold: out_valid && !out_ready keeps every output stable.
- Pop without accept: out_valid falls.
- Pop with accept: back-to-back, full throughput.
- Scoreboard set: accepted instruction with wb[0]=1 sets pend[destType][dest] at that edge.
- Scoreboard clear: wb_valid clears pend[wb_destType][wb_dest].
- Same register set and cleared in one cycle: set wins.
- wb_valid for a non-pending register: write ignored by the scoreboard, no error.
- src1==src2: one hazard check; both operands identical.
- srcType=1 and destType=0 are independent: scalar and vector registers with the same index are distinct.
- Reset mid-operation: held bundle dropped, scoreboard cleared. Writes already in flight downstream are not tracked.

Optional Feature:
- Macro RF_FWD_EN.
- Defined:
  - A source matching (wb_valid, wb_dest, wb_destType) in the accept cycle is not a hazard.
  - Its operand is taken from wb_dataE/wb_dataV instead of rf_r*.
- Undefined:
  - Clearing is registered; a pending bit cleared this cycle still stalls for that cycle.
  - Read proceeds the following cycle from the register file (synchronous-write bank), adding 1 stall cycle.

Test Plan:
- Reset then in_valid, src1=2, src2=3, srcType=0, rf_r1e=0x00005, rf_r2e=0x00007, out_ready=1 -> next cycle out_valid=1, op1e=0x00005, op2e=0x00007, op1v=op2v=0.
- Accept wb[0]=1, dest=4, destType=1; then src1=4, srcType=1 -> in_ready=0 until wb_valid with wb_dest=4, wb_destType=1.
  - RF_FWD_EN defined: accepted in that cycle with op1v=wb_dataV.
  - Undefined: accepted one cycle later.
- out_ready=0 for 3 cycles with the bundle held -> outputs unchanged, in_ready=0; out_ready=1 -> pop and new accept in the same cycle.
- Pending vector register 5, then scalar read of register 5 (srcType=0) -> no stall.
- WAW: pending scalar register 6, new instruction with dest=6, wb[0]=1 -> in_ready=0 until clear.
- rst_n low asynchronously while out_valid=1 and pendE[4]=1 -> out_valid=0 immediately, scoreboard empty, a read of register 4 is accepted after release.
